// File: rtl/imuldiv_int_div_iterative_pkg.sv
// Shared imuldiv message definitions: MulDiv request message, divider fn codes,
// operand/result widths and the iterative divider FSM encoding.
package imuldiv_int_div_iterative_pkg;

  localparam int DIV_OP_W    = 32;
  localparam int DIV_RES_W   = 64;
  localparam int DIV_CNT_W   = 5;

  localparam logic DIV_FN_UNSIGNED = 1'b0;
  localparam logic DIV_FN_SIGNED   = 1'b1;

  typedef enum logic [2:0] {
    MULDIV_FN_MUL  = 3'd0,
    MULDIV_FN_DIV  = 3'd1,
    MULDIV_FN_DIVU = 3'd2,
    MULDIV_FN_REM  = 3'd3,
    MULDIV_FN_REMU = 3'd4
  } muldivreq_fn_e;

  typedef struct packed {
    muldivreq_fn_e         fn;
    logic [DIV_OP_W-1:0]   a;
    logic [DIV_OP_W-1:0]   b;
  } muldivreq_msg_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Two's-complement magnitude when neg is set, identity otherwise.
  function automatic logic [DIV_OP_W-1:0] div_mag(input logic [DIV_OP_W-1:0] v,
                                                  input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/imuldiv_int_div_iterative_dpath.sv
// Divider datapath: operand latches, 65-bit remainder/quotient shift register,
// restoring subtractor, sign fix-up and zero-divisor override.
module imuldiv_int_div_iterative_dpath
  import imuldiv_int_div_iterative_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  prep,
  input  logic                  step,
  input  logic                  done,
  input  logic                  fn,
  input  logic [DIV_OP_W-1:0]   a,
  input  logic [DIV_OP_W-1:0]   b,
  output logic [DIV_RES_W-1:0]  result
);

  logic [DIV_OP_W-1:0] a_reg;
  logic [DIV_OP_W-1:0] b_reg;
  logic [DIV_OP_W-1:0] bmag_reg;
  logic                a_neg_reg;
  logic                b_neg_reg;
  logic [64:0]         rq_reg;

  logic [33:0]         rem_sh;
  logic [33:0]         diff;
  logic [64:0]         rq_step;
  logic [DIV_OP_W-1:0] quo_fix;
  logic [DIV_OP_W-1:0] rem_fix;

  // Raw operands are latched on the request edge; magnitudes are formed in the
  // first CALC cycle so the negation stays off the request input path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      bmag_reg  <= '0;
      a_neg_reg <= 1'b0;
      b_neg_reg <= 1'b0;
      rq_reg    <= '0;
    end else begin
      if (load) begin
        a_reg     <= a;
        b_reg     <= b;
        a_neg_reg <= fn & a[31];
        b_neg_reg <= fn & b[31];
      end
      if (prep) begin
        rq_reg   <= {33'd0, div_mag(a_reg, a_neg_reg)};
        bmag_reg <= div_mag(b_reg, b_neg_reg);
      end else if (step) begin
        rq_reg <= rq_step;
      end
    end
  end

  always_comb begin
    rem_sh  = rq_reg[64:31];
    diff    = rem_sh - {2'b00, bmag_reg};
    rq_step = diff[33] ? {rq_reg[63:0], 1'b0} : {diff[32:0], rq_reg[30:0], 1'b1};
  end

  always_comb begin
    quo_fix = div_mag(rq_reg[31:0], a_neg_reg ^ b_neg_reg);
    rem_fix = div_mag(rq_reg[63:32], a_neg_reg);
    if (b_reg == '0) begin
      quo_fix = '1;
      rem_fix = a_reg;
    end
    result = done ? {rem_fix, quo_fix} : '0;
  end

endmodule

// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit signed/unsigned divider: one prep cycle then 32 restoring
// steps, result {remainder, quotient} held in DONE until accepted.
module imuldiv_int_div_iterative
  import imuldiv_int_div_iterative_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  divreq_msg_fn,
  input  logic [DIV_OP_W-1:0]   divreq_msg_a,
  input  logic [DIV_OP_W-1:0]   divreq_msg_b,
  input  logic                  divreq_val,
  output logic                  divreq_rdy,
  output logic [DIV_RES_W-1:0]  divresp_msg_result,
  output logic                  divresp_val,
  input  logic                  divresp_rdy
);

  div_state_e           state_reg;
  div_state_e           state_next;
  logic [DIV_CNT_W-1:0] count_reg;
  logic [DIV_CNT_W-1:0] count_next;
  logic                 prep_reg;
  logic                 prep_next;

  logic load;
  logic prep;
  logic step;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= DIV_IDLE;
      count_reg <= '0;
      prep_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      prep_reg  <= prep_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    prep_next   = prep_reg;
    load        = 1'b0;
    prep        = 1'b0;
    step        = 1'b0;
    divresp_val = 1'b0;
    case (state_reg)
      DIV_IDLE: begin
        if (divreq_val) begin
          load       = 1'b1;
          state_next = DIV_CALC;
          count_next = '0;
          prep_next  = 1'b1;
        end
      end
      DIV_CALC: begin
        if (prep_reg) begin
          prep      = 1'b1;
          prep_next = 1'b0;
        end else begin
          step       = 1'b1;
          count_next = count_reg + 5'd1;
          if (count_reg == 5'd31) begin
            state_next = DIV_DONE;
          end
        end
      end
      DIV_DONE: begin
        divresp_val = 1'b1;
        if (divresp_rdy) begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  // Ready is masked by reset so it reads 0 while the block is held in reset.
  assign divreq_rdy = (state_reg == DIV_IDLE) && reset;

  imuldiv_int_div_iterative_dpath u_dpath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .prep   (prep),
    .step   (step),
    .done   (state_reg == DIV_DONE),
    .fn     (divreq_msg_fn),
    .a      (divreq_msg_a),
    .b      (divreq_msg_b),
    .result (divresp_msg_result)
  );

endmodule

// File: tb/tb_imuldiv_int_div_iterative.sv
// Self-checking bench for imuldiv_int_div_iterative: scoreboard of expected
// results, directed corner cases, backpressure, reset abort and random traffic.
module tb_imuldiv_int_div_iterative;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        divreq_msg_fn = 1'b0;
  logic [31:0] divreq_msg_a = '0;
  logic [31:0] divreq_msg_b = '0;
  logic        divreq_val = 1'b0;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy = 1'b1;

  int checks = 0;
  int passed = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  imuldiv_int_div_iterative dut (
    .clk                (clk),
    .reset              (reset),
    .divreq_msg_fn      (divreq_msg_fn),
    .divreq_msg_a       (divreq_msg_a),
    .divreq_msg_b       (divreq_msg_b),
    .divreq_val         (divreq_val),
    .divreq_rdy         (divreq_rdy),
    .divresp_msg_result (divresp_msg_result),
    .divresp_val        (divresp_val),
    .divresp_rdy        (divresp_rdy)
  );

  function automatic logic [63:0] model(input bit f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q;
    logic [31:0] r;
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    if (y == 32'd0) begin
      q = 32'hFFFFFFFF; r = x;
    end else if (f && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
      q = 32'h80000000; r = 32'd0;
    end else if (f) begin
      q = sx / sy; r = sx % sy;
    end else begin
      q = x / y; r = x % y;
    end
    return {r, q};
  endfunction

  // Waits (bounded) for ready, presents one request and pushes its expectation.
  task automatic send_req(input bit f, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!divreq_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = divreq_rdy;
    divreq_msg_fn = f;
    divreq_msg_a  = x;
    divreq_msg_b  = y;
    divreq_val    = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    divreq_val    = 1'b0;
    divreq_msg_a  = $urandom;
    divreq_msg_b  = $urandom;
    divreq_msg_fn = 1'($urandom_range(0, 1));
  endtask

  // Counts cycles from the transfer edge until divresp_val; -1 on timeout.
  task automatic wait_resp(output logic [63:0] res, output int lat, output bit quiet);
    lat = -1;
    quiet = 1'b1;
    res = '0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (divresp_val) begin
        lat = i;
        res = divresp_msg_result;
        break;
      end
      if (divresp_msg_result !== 64'd0 || divreq_rdy !== 1'b0) quiet = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (divreq_rdy !== 1'b0 || divresp_val !== 1'b0 || divresp_msg_result !== 64'd0)
      $display("FAIL reset_outputs: rdy=%b val=%b result=%h required rdy=0 val=0 result=0",
               divreq_rdy, divresp_val, divresp_msg_result);
    else passed++;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (divreq_rdy !== 1'b1 || divresp_val !== 1'b0)
      $display("FAIL reset_release_rdy: rdy=%b val=%b required rdy=1 val=0", divreq_rdy, divresp_val);
    else passed++;
    $display("reset: released, rdy=%b", divreq_rdy);
  endtask

  task automatic test_directed;
    bit          fns[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] as[7]   = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'h0000000A, 32'h12345678,
                             32'h80000000, 32'h80000000, 32'h00000064};
    logic [31:0] bs[7]   = '{32'h00000002, 32'h00000002, 32'hFFFFFFFD, 32'h00000000,
                             32'h00000000, 32'hFFFFFFFF, 32'h00000007};
    logic [63:0] exps[7] = '{64'h00000001_7FFFFFFF, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                             64'h12345678_FFFFFFFF, 64'h80000000_FFFFFFFF, 64'h00000000_80000000,
                             64'h00000002_0000000E};
    bit ok;
    bit quiet;
    int lat;
    logic [63:0] res;
    logic [63:0] exp;
    for (int i = 0; i < 7; i++) begin
      send_req(fns[i], as[i], bs[i], exps[i], ok);
      wait_resp(res, lat, quiet);
      exp = sb.pop_front();
      checks++;
      if (!ok || lat !== 33)
        $display("FAIL directed%0d_latency: accepted=%0d latency=%0d required accepted=1 latency=33", i, ok, lat);
      else passed++;
      checks++;
      if (res !== exp)
        $display("FAIL directed%0d_result: got %h required %h", i, res, exp);
      else passed++;
      checks++;
      if (!quiet)
        $display("FAIL directed%0d_busy_outputs: result nonzero or rdy high before DONE", i);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if (divreq_rdy !== 1'b1 || divresp_val !== 1'b0 || divresp_msg_result !== 64'd0)
        $display("FAIL directed%0d_after_xfer: rdy=%b val=%b result=%h required 1 0 0",
                 i, divreq_rdy, divresp_val, divresp_msg_result);
      else passed++;
      $display("directed%0d: fn=%0d a=%h b=%h result=%h lat=%0d", i, fns[i], as[i], bs[i], res, lat);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bit quiet;
    bit stable;
    int lat;
    logic [63:0] res;
    logic [63:0] exp;
    divresp_rdy = 1'b0;
    send_req(1'b0, 32'hDEADBEEF, 32'h00001234, model(1'b0, 32'hDEADBEEF, 32'h00001234), ok);
    wait_resp(res, lat, quiet);
    exp = sb.pop_front();
    checks++;
    if (lat !== 33 || res !== exp)
      $display("FAIL bp_first_resp: latency=%0d result=%h required latency=33 result=%h", lat, res, exp);
    else passed++;
    stable = 1'b1;
    divreq_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (divresp_val !== 1'b1 || divreq_rdy !== 1'b0 || divresp_msg_result !== exp) stable = 1'b0;
    end
    checks++;
    if (!stable)
      $display("FAIL bp_hold: val=%b rdy=%b result=%h required val=1 rdy=0 result=%h",
               divresp_val, divreq_rdy, divresp_msg_result, exp);
    else passed++;
    divreq_val  = 1'b0;
    divresp_rdy = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (divreq_rdy !== 1'b1 || divresp_val !== 1'b0)
      $display("FAIL bp_release: rdy=%b val=%b required rdy=1 val=0", divreq_rdy, divresp_val);
    else passed++;
    $display("backpressure: result=%h held 10 cycles, rdy=%b after release", res, divreq_rdy);
  endtask

  task automatic test_reset_abort;
    bit ok;
    bit quiet;
    bit seen;
    int lat;
    logic [63:0] res;
    logic [63:0] exp;
    send_req(1'b0, 32'hCAFEF00D, 32'h00000003, 64'd0, ok);
    void'(sb.pop_back());
    repeat (11) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (divreq_rdy !== 1'b0 || divresp_val !== 1'b0 || divresp_msg_result !== 64'd0)
      $display("FAIL abort_in_reset: rdy=%b val=%b result=%h required 0 0 0",
               divreq_rdy, divresp_val, divresp_msg_result);
    else passed++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (divreq_rdy !== 1'b1)
      $display("FAIL abort_rdy_after_release: rdy=%b required 1", divreq_rdy);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (divresp_val !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen)
      $display("FAIL abort_no_response: divresp_val asserted for aborted request, required never");
    else passed++;
    send_req(1'b0, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, ok);
    wait_resp(res, lat, quiet);
    exp = sb.pop_front();
    checks++;
    if (lat !== 33 || res !== exp)
      $display("FAIL abort_next_req: latency=%0d result=%h required latency=33 result=%h", lat, res, exp);
    else passed++;
    @(posedge clk);
    #1;
    $display("reset_abort: next request result=%h lat=%0d", res, lat);
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit quiet;
    bit f;
    int lat;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] res;
    logic [63:0] exp;
    for (int i = 0; i < 10; i++) begin
      f = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 20));
        2:       y = -32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      send_req(f, x, y, model(f, x, y), ok);
      wait_resp(res, lat, quiet);
      exp = sb.pop_front();
      checks++;
      if (!ok || lat !== 33 || res !== exp)
        $display("FAIL b2b%0d: fn=%0d a=%h b=%h latency=%0d result=%h required latency=33 result=%h",
                 i, f, x, y, lat, res, exp);
      else passed++;
      $display("b2b%0d: fn=%0d a=%h b=%h result=%h lat=%0d", i, f, x, y, res, lat);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() !== 0)
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
